div_radix4_iter: RTL
====================

# div_radix4_iter

Sequential radix-4 SRT iteration controller for the fixed-point divider. Owns the partial-remainder register, the quotient accumulator and the threshold table, and drives the combinational radix-4 digit-selection LUT. Each cycle it presents the residual estimate, selection constants and scaled divisor to the LUT, then consumes the returned digit q and product −q·d. After the final iteration it applies the sign correction and returns quotient and remainder with a start/done handshake.

## Interface
- WF, 9, fraction width; operands are WF+1 bits; must be odd; ITER = (WF+1)/2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- x  in  WF+1  dividend X (unsigned integer), X < D required
- dv  in  WF+1  divisor D (unsigned), dv[WF]=1 required
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse, results valid
- err  out  1  invalid operands; valid with done
- quo  out  WF+1  Q = floor(X·4^ITER / D), held until next acceptance
- rem  out  WF+1  R = X·4^ITER − Q·D, 0 ≤ R < D
- lutEn  out  1  LUT Enable
- yHat  out  7 signed  residual estimate to LUT
- m2, m1, m0, mm1  out  7 signed each  selection constants to LUT
- dOut  out  WF+5  scaled divisor D' = 4·D, zero-extended
- qIn  in  3 signed  digit from LUT, in {−2..2}
- mqdIn  in  WF+7 signed  −qIn·D' from LUT

## Operation
- FSM states: IDLE, ITER, CORR, DONE.
- IDLE + start, operands valid: W ← X (signed WF+7), Dreg ← D, Qacc ← 0, cnt ← 0; go to ITER.
- IDLE + start, invalid operands (dv[WF]=0 or X ≥ D): go to DONE with err=1, quo = all ones, rem = X.
- ITER: lutEn=1. yHat = (4·W) >>> (WF−1), low 7 bits. Each edge: W ← 4·W + mqdIn; Qacc ← 4·Qacc + qIn (signed, 2·ITER+4 bits); cnt ← cnt+1. Runs ITER+1 cycles, then goes to CORR.
- Threshold table, indexed by Dreg[WF−1:WF−3] = 0..7, entries in order m2/m1/m0/mm1:
  - 0: 12/4/−4/−13
  - 1: 14/4/−6/−15
  - 2: 15/4/−6/−16
  - 3: 16/4/−6/−18
  - 4: 18/6/−8/−20
  - 5: 20/6/−8/−20
  - 6: 20/8/−8/−22
  - 7: 24/8/−8/−24
- Invariant: |W| ≤ (2/3)·D' every cycle. It fits WF+7 bits, and yHat always lies in ±43.
- CORR:
  - If W < 0: Q = Qacc − 1 and R = (W + D')/4.
  - Otherwise: Q = Qacc and R = W/4.
  - Register quo and rem from the low WF+1 bits; go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- Outputs are registered from state, except the LUT-side outputs. yHat and the constants are combinational from W and Dreg. dOut = {Dreg, 2'b00}, zero-extended.
- start outside IDLE is ignored and not queued.

## Timing
- Reset values:
  - state=IDLE; busy=0, done=0, err=0, lutEn=0.
  - quo=0, rem=0, W=0, Dreg=0, Qacc=0, cnt=0.
  - m-outputs reflect the index-0 entry; yHat=0.
- Latency, valid operands: start at edge k gives done high during cycle k+ITER+3 (WF=9: 8 cycles).
- Latency, invalid operands: done high during cycle k+1.
- busy rises at the acceptance edge and falls with the done pulse.
- start may be asserted in the cycle done is high. It is accepted at the next IDLE edge and is never dropped silently.
- rst_n low mid-operation: immediate return to reset values; no done pulse.
- qIn/mqdIn are sampled only in ITER. They are ignored otherwise, since the LUT drives 0 while lutEn=0.

## Configuration
- DIV_REM_EN defined: remainder correction adder and rem register built as specified.
- DIV_REM_EN undefined: rem tied to 0 and no remainder adder. quo, err, done and latency are unchanged.

## Test plan
- WF=9, X=256, D=512 → done after 8 cycles; quo=512, rem=0, err=0.
- X=1000, D=1001 → quo=1022, rem=978; negative final W exercises the correction.
- X=1, D=1023 → quo=1, rem=1. Sweep all 8 divisor indices against a reference model and check |W| ≤ 2D'/3 each cycle.
- D=300 (unnormalised), X=5 → done after 1 cycle; err=1, quo=1023, rem=5. Repeat with X=D=600 → err=1.
- start pulsed during ITER is ignored. Back-to-back start in the done cycle produces a second done exactly 8 cycles later.
- rst_n low at cnt=3 → all outputs at reset values, no done pulse. Next start completes correctly.

Source files
------------

// File: rtl/div_radix4_iter.sv
// Radix-4 SRT divider iteration controller. It owns the residual W, the quotient accumulator and the threshold table, and drives an external digit LUT.
// Latency: done is registered ITER+2 edges after a valid acceptance, or at the acceptance edge for invalid operands.
// Backpressure: none. start is taken in IDLE or in the DONE cycle and is ignored while busy. Build option DIV_REM_EN adds the remainder path.
module div_radix4_iter #(
  parameter int WF = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WF:0]          x,
  input  logic [WF:0]          dv,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WF:0]          quo,
  output logic [WF:0]          rem,
  output logic                 lutEn,
  output logic signed [6:0]    yHat,
  output logic signed [6:0]    m2,
  output logic signed [6:0]    m1,
  output logic signed [6:0]    m0,
  output logic signed [6:0]    mm1,
  output logic [WF+4:0]        dOut,
  input  logic signed [2:0]    qIn,
  input  logic signed [WF+6:0] mqdIn
);

  localparam int ITER = (WF + 1) / 2;
  localparam int WW   = WF + 7;
  localparam int QW   = 2 * ITER + 4;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_CORR = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state;
  logic signed [WW-1:0] w;
  logic [WF:0]          dreg;
  logic signed [QW-1:0] qacc;
  logic [CW-1:0]        cnt;
  logic                 bad_op;
  logic                 w_neg;
  logic [2:0]           tidx;

  // Operands are rejected if the divisor is not normalised or the quotient would overflow.
  assign bad_op = !dv[WF] || (x >= dv);
  assign w_neg  = w[WW-1];
  assign lutEn  = (state == S_ITER);
  // (4*W) >>> (WF-1) keeps seven bits, which is a plain slice of W.
  assign yHat   = w[WF+3:WF-3];
  assign dOut   = {2'b00, dreg, 2'b00};
  assign tidx   = dreg[WF-1:WF-3];

  // Selection thresholds depend on the three divisor bits just below the leading one.
  always_comb begin
    m2  = 7'sd12;
    m1  = 7'sd4;
    m0  = -7'sd4;
    mm1 = -7'sd13;
    case (tidx)
      3'd1: begin m2 = 7'sd14; m1 = 7'sd4; m0 = -7'sd6; mm1 = -7'sd15; end
      3'd2: begin m2 = 7'sd15; m1 = 7'sd4; m0 = -7'sd6; mm1 = -7'sd16; end
      3'd3: begin m2 = 7'sd16; m1 = 7'sd4; m0 = -7'sd6; mm1 = -7'sd18; end
      3'd4: begin m2 = 7'sd18; m1 = 7'sd6; m0 = -7'sd8; mm1 = -7'sd20; end
      3'd5: begin m2 = 7'sd20; m1 = 7'sd6; m0 = -7'sd8; mm1 = -7'sd20; end
      3'd6: begin m2 = 7'sd20; m1 = 7'sd8; m0 = -7'sd8; mm1 = -7'sd22; end
      3'd7: begin m2 = 7'sd24; m1 = 7'sd8; m0 = -7'sd8; mm1 = -7'sd24; end
      default: ;
    endcase
  end

`ifndef DIV_REM_EN
  assign rem = '0;
`endif

  // Control FSM plus the residual, quotient and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      quo   <= '0;
      w     <= '0;
      dreg  <= '0;
      qacc  <= '0;
      cnt   <= '0;
`ifdef DIV_REM_EN
      rem   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // The DONE cycle also accepts, so a start raised alongside done is not lost.
        S_IDLE, S_DONE: begin
          if (start) begin
            if (bad_op) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              quo   <= '1;
`ifdef DIV_REM_EN
              rem   <= x;
`endif
            end else begin
              state <= S_ITER;
              busy  <= 1'b1;
              err   <= 1'b0;
              w     <= {{(WW-WF-1){1'b0}}, x};
              dreg  <= dv;
              qacc  <= '0;
              cnt   <= '0;
            end
          end else if (state == S_DONE) begin
            state <= S_IDLE;
          end
        end
        S_ITER: begin
          w    <= (w <<< 2) + mqdIn;
          qacc <= (qacc <<< 2) + QW'(qIn);
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_CORR;
          end
        end
        // A negative final residual means the last digit overshot by one.
        S_CORR: begin
          quo   <= qacc[WF:0] - {{WF{1'b0}}, w_neg};
`ifdef DIV_REM_EN
          rem   <= w[WF+2:2] + (w_neg ? dreg : '0);
`endif
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
